cpu_mem_arbiter: RTL and testbench

- Shares the single external memory bus between the instruction-fetch port and the data (load/store) port of the 5-stage pipeline.
- Sequences one bus transaction at a time: it accepts requests, grants the bus, waits for the bus ack, and returns a registered ack and read data to the winning requester.
- Drives the pipeline-wide stall while any request is pending.
- Sits between the IF/MEM stages and the memory-mapped bus.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/cpu_mem_arbiter_if.sv | 40 ++++
 rtl/cpu_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter state encoding and default widths/limits.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ARB_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_D = 3'd1,
    GRANT_I = 3'd2,
    DONE_D  = 3'd3,
    DONE_I  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Signal bundle between the IF/MEM stages, the memory arbiter and the external bus.
interface cpu_mem_arbiter_if import cpu_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              c_stall;
  logic              arb_err;

  // Arbiter side: answers the pipeline ports and drives the bus.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, bus_rdata, bus_ack,
    output if_rdata, if_ack, d_rdata, d_ack, bus_req, bus_we, bus_addr, bus_wdata,
    output c_stall, arb_err
  );

  // Environment side: pipeline requesters plus the bus responder.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, bus_rdata, bus_ack,
    input  if_rdata, if_ack, d_rdata, d_ack, bus_req, bus_we, bus_addr, bus_wdata,
    input  c_stall, arb_err
  );

endinterface

// File: rtl/cpu_mem_arbiter.sv
// Fetch/data arbiter for the single memory bus, one transaction at a time, data first.
// Define CPU_ARB_TIMEOUT_EN to add the TIMEOUT bus-wait limit and the arb_err pulse.
module cpu_mem_arbiter import cpu_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef CPU_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = ARB_TIMEOUT
`endif
) (
  input logic              clk,
  input logic              rst,
  cpu_mem_arbiter_if.slave bif
);

  arb_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              finish;
  logic [DATA_W-1:0] fin_data;

`ifdef CPU_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        arb_err_q, arb_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    finish      = 1'b0;
    fin_data    = '0;
`ifdef CPU_ARB_TIMEOUT_EN
    wait_cnt_d  = '0;
    arb_err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bif.d_req) begin
          state_d     = GRANT_D;
          bus_req_d   = 1'b1;
          bus_we_d    = bif.d_we;
          bus_addr_d  = bif.d_addr;
          bus_wdata_d = bif.d_wdata;
        end else if (bif.if_req) begin
          state_d    = GRANT_I;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = bif.if_addr;
        end
      end
      GRANT_D, GRANT_I: begin
        if (bif.bus_ack && bus_req_q) begin
          finish   = 1'b1;
          fin_data = bif.bus_rdata;
        end
`ifdef CPU_ARB_TIMEOUT_EN
        else begin
          // Saturating count; a same-cycle bus_ack above wins over expiry.
          wait_cnt_d = (wait_cnt_q == TimeoutCnt) ? wait_cnt_q : wait_cnt_q + 16'd1;
          if (wait_cnt_d == TimeoutCnt) begin
            finish    = 1'b1;
            arb_err_d = 1'b1;
          end
        end
`endif
      end
      DONE_D, DONE_I: state_d = IDLE;
      default:        state_d = IDLE;
    endcase

    if (finish) begin
      bus_req_d = 1'b0;
      bus_we_d  = 1'b0;
      if (state_q == GRANT_D) begin
        state_d   = DONE_D;
        d_ack_d   = 1'b1;
        d_rdata_d = fin_data;
      end else begin
        state_d    = DONE_I;
        if_ack_d   = 1'b1;
        if_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef CPU_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      arb_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      arb_err_q  <= arb_err_d;
    end
  end

  assign bif.arb_err = arb_err_q;
`else
  assign bif.arb_err = 1'b0;
`endif

  assign bif.bus_req   = bus_req_q;
  assign bif.bus_we    = bus_we_q;
  assign bif.bus_addr  = bus_addr_q;
  assign bif.bus_wdata = bus_wdata_q;
  assign bif.if_ack    = if_ack_q;
  assign bif.d_ack     = d_ack_q;
  assign bif.if_rdata  = if_rdata_q;
  assign bif.d_rdata   = d_rdata_q;
  // Stall is combinational so a new request freezes the pipeline in the same cycle.
  assign bif.c_stall   = (bif.if_req & ~if_ack_q) | (bif.d_req & ~d_ack_q);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized bench for cpu_mem_arbiter: a transaction-level memory model predicts read data,
// ordering and latencies; the bus side is a small memory responder with random wait states.
module tb_cpu_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

`ifdef CPU_ARB_TIMEOUT_EN
  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .bif(bif));
  localparam int KMax  = 3;
  localparam int KWait = 3;
`else
  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .bif(bif));
  localparam int KMax  = 6;
  localparam int KWait = 5;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // ref_mem: what the CPU expects memory to hold; bus_mem: what the bus actually saw written.
  logic [31:0] ref_mem [16];
  logic [31:0] bus_mem [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue fetch and/or data request in the current IDLE cycle and follow both to completion.
  task automatic run_op(input bit do_i, input logic [31:0] ia, input bit do_d, input bit dwe,
                        input logic [31:0] da, input logic [31:0] dwd, input int k_fix);
    bit          is_d;
    logic [31:0] a, exp_rd, drv_rd;
    int          nt, k, gap;
    bif.if_req  = do_i;
    bif.if_addr = ia;
    bif.d_req   = do_d;
    bif.d_we    = dwe;
    bif.d_addr  = da;
    bif.d_wdata = dwd;
    #1 check("stall_on_req", {31'd0, bif.c_stall}, {31'd0, do_i | do_d});
    nt = (do_i ? 1 : 0) + (do_d ? 1 : 0);
    for (int j = 0; j < nt; j++) begin
      is_d = do_d && (j == 0);
      a    = is_d ? da : ia;
      gap  = (j == 0) ? 1 : 2;
      for (int w = 1; w <= gap; w++) begin
        @(negedge clk);
        if (w < gap) check("idle_gap", {31'd0, bif.bus_req}, 32'd0);
        check("no_dup_ack", {30'd0, bif.if_ack, bif.d_ack}, 32'd0);
      end
      check("grant_req", {31'd0, bif.bus_req}, 32'd1);
      check("grant_addr", bif.bus_addr, a);
      check("grant_we", {31'd0, bif.bus_we}, {31'd0, is_d & dwe});
      if (is_d && dwe) check("grant_wdata", bif.bus_wdata, dwd);
      k = (k_fix >= 0) ? k_fix : int'($urandom_range(0, KMax));
      for (int c = 0; c < k; c++) begin
        @(negedge clk);
        check("wait_req", {31'd0, bif.bus_req}, 32'd1);
        check("wait_addr", bif.bus_addr, a);
        if (is_d && dwe) check("wait_wdata", bif.bus_wdata, dwd);
        check("wait_ack", {30'd0, bif.if_ack, bif.d_ack}, 32'd0);
        check("wait_stall", {31'd0, bif.c_stall}, 32'd1);
      end
      if (is_d && dwe) begin
        ref_mem[a[5:2]] = dwd;
        drv_rd = $urandom();
        exp_rd = drv_rd;
      end else begin
        exp_rd = ref_mem[a[5:2]];
        drv_rd = bus_mem[bif.bus_addr[5:2]];
      end
      if (bif.bus_we) bus_mem[bif.bus_addr[5:2]] = bif.bus_wdata;
      bif.bus_ack   = 1'b1;
      bif.bus_rdata = drv_rd;
      @(negedge clk);
      bif.bus_ack   = 1'b0;
      bif.bus_rdata = $urandom();
      check("ack_i", {31'd0, bif.if_ack}, {31'd0, !is_d});
      check("ack_d", {31'd0, bif.d_ack}, {31'd0, is_d});
      if (is_d) check("rdata_d", bif.d_rdata, exp_rd);
      else      check("rdata_i", bif.if_rdata, exp_rd);
      check("done_bus_req", {31'd0, bif.bus_req}, 32'd0);
      check("done_err", {31'd0, bif.arb_err}, 32'd0);
      check("done_stall", {31'd0, bif.c_stall}, {31'd0, do_i & is_d});
      if (is_d) bif.d_req = 1'b0;
      else      bif.if_req = 1'b0;
    end
    @(negedge clk);
    check("tail_req", {31'd0, bif.bus_req}, 32'd0);
    check("tail_ack", {30'd0, bif.if_ack, bif.d_ack}, 32'd0);
    check("tail_stall", {31'd0, bif.c_stall}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rw, val;
    logic [3:0]  ix;
    int          mode;

    for (int i = 0; i < 16; i++) begin
      val        = $urandom();
      ref_mem[i] = val;
      bus_mem[i] = val;
    end
    ref_mem[0] = 32'h2408_0005;
    bus_mem[0] = 32'h2408_0005;

    rst = 1'b1;
    bif.if_req = 1'b0; bif.if_addr = '0;
    bif.d_req = 1'b0; bif.d_we = 1'b0; bif.d_addr = '0; bif.d_wdata = '0;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("rst_bus_req", {31'd0, bif.bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bif.bus_we}, 32'd0);
    check("rst_bus_addr", bif.bus_addr, 32'd0);
    check("rst_bus_wdata", bif.bus_wdata, 32'd0);
    check("rst_acks", {30'd0, bif.if_ack, bif.d_ack}, 32'd0);
    check("rst_if_rdata", bif.if_rdata, 32'd0);
    check("rst_d_rdata", bif.d_rdata, 32'd0);
    check("rst_err", {31'd0, bif.arb_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    check("stray_ack_idle", {29'd0, bif.bus_req, bif.if_ack, bif.d_ack}, 32'd0);

    // Fetch only, one wait cycle: if_ack three cycles after if_req.
    run_op(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 32'd0, 1);
    check("fetch_rdata", bif.if_rdata, 32'h2408_0005);
    // Collision: the data store goes first, then the fetch.
    run_op(1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h1000_0000, 32'hCAFE_F00D, 0);
    // Long wait states.
    run_op(1'b0, 32'd0, 1'b1, 1'b0, 32'h1000_0000, 32'd0, KWait);

    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 2));
      ix = 4'($urandom_range(0, 15)); ra = $urandom(); ra = {ra[31:6], ix, 2'b00};
      ix = 4'($urandom_range(0, 15)); rb = $urandom(); rb = {rb[31:6], ix, 2'b00};
      rw = $urandom();
      run_op(mode != 1, ra, mode != 0, rw[0], rb, $urandom(), -1);
    end

    // Reset in the second GRANT_D cycle abandons the store.
    bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_addr = 32'h1000_0010; bif.d_wdata = 32'h1234_5678;
    @(negedge clk);
    check("rst_mid_grant", {31'd0, bif.bus_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bif.d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_req", {31'd0, bif.bus_req}, 32'd0);
    check("rst_mid_ack", {30'd0, bif.if_ack, bif.d_ack}, 32'd0);
    bif.bus_ack = 1'b1;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    check("rst_stray_ack", {29'd0, bif.bus_req, bif.if_ack, bif.d_ack}, 32'd0);
    @(negedge clk);
    check("rst_stray_ack2", {29'd0, bif.bus_req, bif.if_ack, bif.d_ack}, 32'd0);

    // Make d_rdata nonzero so a forced zero is visible.
    bus_mem[5] = 32'hA5A5_0001; ref_mem[5] = 32'hA5A5_0001;
    run_op(1'b0, 32'd0, 1'b1, 1'b0, 32'h1000_0014, 32'd0, 0);

    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h1000_0018;
`ifdef CPU_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("to_wait_req", {31'd0, bif.bus_req}, 32'd1);
      check("to_wait_err", {31'd0, bif.arb_err}, 32'd0);
    end
    @(negedge clk);
    check("to_ack", {31'd0, bif.d_ack}, 32'd1);
    check("to_err", {31'd0, bif.arb_err}, 32'd1);
    check("to_rdata", bif.d_rdata, 32'd0);
    check("to_bus_req", {31'd0, bif.bus_req}, 32'd0);
    bif.d_req = 1'b0;
    @(negedge clk);
    check("to_err_pulse", {30'd0, bif.arb_err, bif.d_ack}, 32'd0);
    // Ack in the expiry cycle completes normally.
    run_op(1'b0, 32'd0, 1'b1, 1'b0, 32'h1000_0014, 32'd0, 3);
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_req", {31'd0, bif.bus_req}, 32'd1);
      check("hold_err_ack", {30'd0, bif.arb_err, bif.d_ack}, 32'd0);
    end
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    check("hold_ack", {31'd0, bif.d_ack}, 32'd1);
    check("hold_rdata", bif.d_rdata, 32'h0BAD_F00D);
    bif.d_req = 1'b0;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
